// File: rtl/vec_mag_pkg.sv
// vec_mag_pkg
//   Shared types and width helpers for the sequential vector-magnitude unit.
//   state_t  : controller states (IDLE, SQ, ITER, DONE)
//   sum_w    : width of s = x*x + y*y for W-bit operands (2W+1)
//   mag_w    : width of the magnitude result (W+1)
//   rem_w    : width of the floor remainder (W+2)
//   cnt_w    : width of the iteration counter (holds W+1)
package vec_mag_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SQ,
        ITER,
        DONE
    } state_t;

    function automatic int sum_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int mag_w(input int w);
        return w + 1;
    endfunction

    function automatic int rem_w(input int w);
        return w + 2;
    endfunction

    function automatic int cnt_w(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/vec_magnitude_seq_isqrt_step.sv
// isqrt_step
//   One combinational step of the digit-recurrence integer square root.
//   rem_acc / root / trial : current working remainder, partial root, trial bit
//   rem_acc_nxt / root_nxt / trial_nxt : values after this step
//   Parameter SW is the working width (wide enough for s).
module isqrt_step #(
    parameter int unsigned SW = 17
) (
    input  logic [SW-1:0] rem_acc,
    input  logic [SW-1:0] root,
    input  logic [SW-1:0] trial,
    output logic [SW-1:0] rem_acc_nxt,
    output logic [SW-1:0] root_nxt,
    output logic [SW-1:0] trial_nxt
);

    logic [SW-1:0] cand;

    always_comb begin
        cand        = root + trial;
        trial_nxt   = trial >> 2;
        rem_acc_nxt = rem_acc;
        root_nxt    = root >> 1;
        if (rem_acc >= cand) begin
            rem_acc_nxt = rem_acc - cand;
            root_nxt    = (root >> 1) + trial;
        end
    end

endmodule

// File: rtl/vec_magnitude_seq.sv
// vec_magnitude_seq
//   Sequential magnitude unit: mag = sqrt(x*x + y*y), one root bit per cycle.
//   clk, rst       : clock (rising edge) and synchronous active-high reset
//   in_valid/ready : operand handshake for x, y (W-bit unsigned)
//   out_valid/ready: result handshake for mag (W+1 bits) and rem (W+2 bits)
//   busy           : high while squaring or iterating
//   ROUND=0 gives floor(sqrt(s)); ROUND=1 gives the nearest integer.
//   rem is always the floor remainder s - floor(sqrt(s))^2.
module vec_magnitude_seq
    import vec_mag_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter bit          ROUND = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   mag,
    output logic [W+1:0] rem,
    output logic         busy
);

    localparam int SUM_W = sum_w(W);
    localparam int MAG_W = mag_w(W);
    localparam int REM_W = rem_w(W);
    localparam int CNT_W = cnt_w(W);

    localparam logic [SUM_W-1:0] TRIAL_INIT = {1'b1, {(2 * W){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

    state_t state_q, state_d;

    logic [W-1:0]     x_q, y_q;
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] rem_acc_q, root_q, trial_q;
    logic [SUM_W-1:0] rem_acc_nxt, root_nxt, trial_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [MAG_W-1:0] mag_q, mag_fin;
    logic [REM_W-1:0] rem_q;
    logic             rnd_up;
    logic             unused_hi_bits;

    isqrt_step #(
        .SW (SUM_W)
    ) u_step (
        .rem_acc     (rem_acc_q),
        .root        (root_q),
        .trial       (trial_q),
        .rem_acc_nxt (rem_acc_nxt),
        .root_nxt    (root_nxt),
        .trial_nxt   (trial_nxt)
    );

    // The working root/remainder must be as wide as s while the recurrence
    // runs; after the last step they fit in MAG_W / REM_W bits.
    assign unused_hi_bits = ^{root_nxt[SUM_W-1:MAG_W], rem_acc_nxt[SUM_W-1:REM_W]};

    always_comb begin
        s = {{(W + 1){1'b0}}, x_q} * {{(W + 1){1'b0}}, x_q}
          + {{(W + 1){1'b0}}, y_q} * {{(W + 1){1'b0}}, y_q};
    end

    // sqrt(s) >= r + 0.5  <=>  s - r*r > r for integer s, r.
    always_comb begin
        rnd_up  = ROUND && (rem_acc_nxt > root_nxt);
        mag_fin = root_nxt[MAG_W-1:0] + MAG_W'(rnd_up);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = SQ;
            SQ:      state_d = ITER;
            ITER:    if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? SQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
        out_valid = (state_q == DONE);
        busy      = (state_q == SQ) || (state_q == ITER);
        mag       = mag_q;
        rem       = rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            rem_acc_q <= '0;
            root_q    <= '0;
            trial_q   <= '0;
            cnt_q     <= '0;
            mag_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q <= state_d;
            if (in_valid && in_ready) begin
                x_q <= x;
                y_q <= y;
            end
            unique case (state_q)
                SQ: begin
                    rem_acc_q <= s;
                    root_q    <= '0;
                    trial_q   <= TRIAL_INIT;
                    cnt_q     <= CNT_INIT;
                end
                ITER: begin
                    rem_acc_q <= rem_acc_nxt;
                    root_q    <= root_nxt;
                    trial_q   <= trial_nxt;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        mag_q <= mag_fin;
                        rem_q <= rem_acc_nxt[REM_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_magnitude_seq.sv
// tb_vec_magnitude_seq
//   Directed and random checks of vec_magnitude_seq at W=8. Two instances
//   (floor and rounded) run in lockstep on the same stimulus.
module tb_vec_magnitude_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] x, y;

    logic       in_ready0, out_valid0, busy0;
    logic [8:0] mag0;
    logic [9:0] rem0;
    logic       in_ready1, out_valid1, busy1;
    logic [8:0] mag1;
    logic [9:0] rem1;

    int compared   = 0;
    int mismatched = 0;
    int lat, bcnt, saw;

    always #5 clk = ~clk;

    vec_magnitude_seq #(.W(8), .ROUND(1'b0)) dut_floor (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .x(x), .y(y), .out_valid(out_valid0), .out_ready(out_ready),
        .mag(mag0), .rem(rem0), .busy(busy0)
    );

    vec_magnitude_seq #(.W(8), .ROUND(1'b1)) dut_round (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .x(x), .y(y), .out_valid(out_valid1), .out_ready(out_ready),
        .mag(mag1), .rem(rem1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_floor(input int s);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    function automatic int ref_round(input int s);
        int r;
        r = ref_floor(s);
        return ((s - r * r) > ((r + 1) * (r + 1) - s)) ? r + 1 : r;
    endfunction

    // Called just after a negedge; returns at the negedge after the accept edge.
    task automatic launch(input int xv, input int yv);
        in_valid = 1'b1;
        x = 8'(xv);
        y = 8'(yv);
        #1;
        check("in_ready_at_launch", {31'd0, in_ready0}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x = '0;
        y = '0;
    endtask

    // Counts negedges until out_valid; busy is sampled on each pre-result negedge.
    task automatic wait_result(output int l, output int b);
        l = 0;
        b = 0;
        while (!out_valid0 && l < 40) begin
            if (busy0) b++;
            @(negedge clk);
            l++;
        end
        check("result_timeout", {31'd0, out_valid0}, 32'd1);
    endtask

    task automatic check_res(input string tag, input int m0, input int r0, input int m1);
        check({tag, "_mag_floor"}, {23'd0, mag0}, m0);
        check({tag, "_rem"},       {22'd0, rem0}, r0);
        check({tag, "_mag_round"}, {23'd0, mag1}, m1);
        check({tag, "_rem_round"}, {22'd0, rem1}, r0);
        check({tag, "_valid_round"}, {31'd0, out_valid1}, 32'd1);
    endtask

    task automatic op(input string tag, input int xv, input int yv,
                      input int m0, input int r0, input int m1);
        int l, b;
        launch(xv, yv);
        wait_result(l, b);
        check_res(tag, m0, r0, m1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        y         = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready",  {31'd0, in_ready0},  32'd0);
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_busy",      {31'd0, busy0},      32'd0);
        check("rst_mag",       {23'd0, mag0},       32'd0);
        check("rst_rem",       {22'd0, rem0},       32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready0}, 32'd1);

        // (3,4): latency and busy span (one SQ cycle plus W+1 ITER cycles)
        launch(3, 4);
        wait_result(lat, bcnt);
        check("lat_3_4",  lat,  32'd10);
        check("busy_3_4", bcnt, 32'd10);
        check_res("op_3_4", 5, 0, 5);

        // Maximum operands: s=130050, 360^2=129600
        op("op_255_255", 255, 255, 360, 450, 361);

        // Small operands
        op("op_0_0", 0, 0, 0, 0, 0);
        op("op_1_1", 1, 1, 1, 1, 1);
        op("op_2_3", 2, 3, 3, 4, 4);

        // Backpressure: drain, then hold the result for 5 cycles
        @(negedge clk);
        out_ready = 1'b0;
        launch(255, 255);
        wait_result(lat, bcnt);
        check_res("bp_first", 360, 450, 361);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid0}, 32'd1);
            check("bp_mag",       {23'd0, mag0},       32'd360);
            check("bp_rem",       {22'd0, rem0},       32'd450);
            check("bp_in_ready",  {31'd0, in_ready0},  32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x = 8'd3;
        y = 8'd4;
        #1;
        check("bp_release_in_ready", {31'd0, in_ready0}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_after_out_valid", {31'd0, out_valid0}, 32'd0);
        check("bp_after_busy",      {31'd0, busy0},      32'd1);
        check("bp_mag_held",        {23'd0, mag0},       32'd360);
        wait_result(lat, bcnt);
        check("bp_next_lat", lat, 32'd10);
        check_res("bp_next", 5, 0, 5);

        // Reset during the fourth ITER cycle
        @(negedge clk);
        launch(255, 255);
        repeat (4) @(negedge clk);
        check("abort_busy_before", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid0}, 32'd0);
        check("abort_mag",       {23'd0, mag0},       32'd0);
        check("abort_rem",       {22'd0, rem0},       32'd0);
        check("abort_busy",      {31'd0, busy0},      32'd0);
        check("abort_in_ready",  {31'd0, in_ready0},  32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready_after", {31'd0, in_ready0}, 32'd1);
        saw = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid0 || out_valid1 || busy0) saw++;
        end
        check("abort_no_result", saw, 32'd0);

        // Random operands against the reference square root
        for (int i = 0; i < 400; i++) begin
            int xv, yv, s, rf;
            xv = int'($urandom_range(0, 255));
            yv = int'($urandom_range(0, 255));
            s  = xv * xv + yv * yv;
            rf = ref_floor(s);
            op("rand", xv, yv, rf, s - rf * rf, ref_round(s));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
